// File: rtl/conv_layer_sequencer.sv
// Per-sample scheduler for a chained dilated conv1d stack.
// Each rising edge of sample_clk runs one inference pass: clock the input
// shift buffers, start each layer in turn, wait for its out_v, clock that
// layer's activation cache, then strobe the final output latch.
// Also reports pass timing, dropped sample edges and stuck layers.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   sample_clk     sample strobe (synchronous to clk), edge-detected here
//   lsb_clk        1-cycle pulse: shift buffers capture a sample
//   conv_rst       one-hot 1-cycle pulse: start conv layer i
//   conv_out_v     out_v of conv layer i
//   cache_clk      1-cycle pulse: activation cache i captures layer i output
//   out_latch      1-cycle pulse: last layer output valid
//   busy           high while a pass is in progress
//   timeout_err    sticky, a layer never produced out_v
//   overrun_cnt    sample edges dropped while busy (saturating)
//   last_cycles    length of last completed pass in cycles
//   max_cycles     largest last_cycles since reset
module conv_layer_sequencer #(
    parameter int unsigned N_LAYERS = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         sample_clk,
    output logic                                         lsb_clk,
    output logic [N_LAYERS-1:0]                          conv_rst,
    input  logic [N_LAYERS-1:0]                          conv_out_v,
    output logic [((N_LAYERS > 1) ? N_LAYERS - 1 : 1)-1:0] cache_clk,
    output logic                                         out_latch,
    output logic                                         busy,
    output logic                                         timeout_err,
    output logic [CNT_W-1:0]                             overrun_cnt,
    output logic [CNT_W-1:0]                             last_cycles,
    output logic [CNT_W-1:0]                             max_cycles
);

    localparam int unsigned CACHE_W = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;
    localparam int unsigned IDX_W   = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 2);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE, CLK_LSB, RST_CONV, RUN_CONV, CLK_CACHE, OUTPUT
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    logic                 prev_sample_q;
    logic                 timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]     overrun_q, overrun_d;
    logic [CNT_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     max_q, max_d;
    logic                 lsb_clk_q, lsb_clk_d;
    logic [N_LAYERS-1:0]  conv_rst_q, conv_rst_d;
    logic [CACHE_W-1:0]   cache_clk_q, cache_clk_d;
    logic                 out_latch_q, out_latch_d;
    logic                 busy_q, busy_d;
    logic                 edge_c;

    // Next-state, counters and strobe decode
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        cyc_d         = cyc_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q;
        last_d        = last_q;
        max_d         = max_q;
        edge_c        = sample_clk & ~prev_sample_q;

        // Pass length counts every busy cycle; edges while busy are dropped
        if (state_q != IDLE) begin
            if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_W'(1);
            if (edge_c && (overrun_q != CNT_MAX)) overrun_d = overrun_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (edge_c) begin
                    state_d = CLK_LSB;
                    cyc_d   = CNT_W'(1);
                end
            end
            CLK_LSB: begin
                idx_d   = '0;
                state_d = RST_CONV;
            end
            RST_CONV: begin
                wait_d  = '0;
                state_d = RUN_CONV;
            end
            RUN_CONV: begin
                // wait_q == 0 is the first RUN cycle: a valid left over from
                // the previous pass may still be high, so it is not trusted
                if ((wait_q != '0) && conv_out_v[idx_q]) begin
                    state_d = (idx_q == LAST_IDX) ? OUTPUT : CLK_CACHE;
                end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            CLK_CACHE: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = RST_CONV;
            end
            OUTPUT: begin
                last_d  = cyc_q;
                if (cyc_q > max_q) max_d = cyc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        lsb_clk_d   = (state_d == CLK_LSB);
        conv_rst_d  = (state_d == RST_CONV) ? (N_LAYERS'(1) << idx_d) : '0;
        cache_clk_d = (state_d == CLK_CACHE) ? (CACHE_W'(1) << idx_d) : '0;
        out_latch_d = (state_d == OUTPUT);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        prev_sample_q <= sample_clk;
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            wait_q        <= '0;
            cyc_q         <= '0;
            timeout_err_q <= 1'b0;
            overrun_q     <= '0;
            last_q        <= '0;
            max_q         <= '0;
            lsb_clk_q     <= 1'b0;
            conv_rst_q    <= '0;
            cache_clk_q   <= '0;
            out_latch_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wait_q        <= wait_d;
            cyc_q         <= cyc_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            last_q        <= last_d;
            max_q         <= max_d;
            lsb_clk_q     <= lsb_clk_d;
            conv_rst_q    <= conv_rst_d;
            cache_clk_q   <= cache_clk_d;
            out_latch_q   <= out_latch_d;
            busy_q        <= busy_d;
        end
    end

    assign lsb_clk     = lsb_clk_q;
    assign conv_rst    = conv_rst_q;
    assign cache_clk   = cache_clk_q;
    assign out_latch   = out_latch_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun_cnt = overrun_q;
    assign last_cycles = last_q;
    assign max_cycles  = max_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (3 layers, TIMEOUT=8).
// Strobes are folded into a nibble signature per pass:
//   1 lsb_clk, 2/3/4 conv_rst[0..2], 5/6 cache_clk[0..1], 7 out_latch.
module tb_conv_layer_sequencer;

    localparam int unsigned N_LAYERS = 3;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned TIMEOUT  = 8;

    localparam logic [63:0] SIG_FULL    = 64'h1253647;
    localparam logic [63:0] SIG_TIMEOUT = 64'h125364;
    localparam logic [63:0] SIG_CACHE0  = 64'h125;

    logic                clk;
    logic                rst;
    logic                sample_clk;
    logic                lsb_clk;
    logic [N_LAYERS-1:0] conv_rst;
    logic [N_LAYERS-1:0] conv_out_v;
    logic [N_LAYERS-2:0] cache_clk;
    logic                out_latch;
    logic                busy;
    logic                timeout_err;
    logic [CNT_W-1:0]    overrun_cnt;
    logic [CNT_W-1:0]    last_cycles;
    logic [CNT_W-1:0]    max_cycles;

    int          checks;
    int          failures;
    int          multi;
    int          run_last;
    logic [63:0] sig;

    conv_layer_sequencer #(
        .N_LAYERS (N_LAYERS),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clk  (sample_clk),
        .lsb_clk     (lsb_clk),
        .conv_rst    (conv_rst),
        .conv_out_v  (conv_out_v),
        .cache_clk   (cache_clk),
        .out_latch   (out_latch),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_cnt (overrun_cnt),
        .last_cycles (last_cycles),
        .max_cycles  (max_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Append this cycle's strobes to the signature; flag overlapping strobes
    task automatic sample_strobes();
        int n;
        n = 0;
        if (lsb_clk) begin sig = {sig[59:0], 4'h1}; n++; end
        for (int i = 0; i < 3; i++)
            if (conv_rst[i]) begin sig = {sig[59:0], 4'(2 + i)}; n++; end
        for (int i = 0; i < 2; i++)
            if (cache_clk[i]) begin sig = {sig[59:0], 4'(5 + i)}; n++; end
        if (out_latch) begin sig = {sig[59:0], 4'h7}; n++; end
        if (n > 1) multi++;
    endtask

    // One pass: r[i] = RUN cycle (1-based) in which layer i raises out_v, 0 = never.
    // hold0 keeps out_v[0] high all pass; ovr_layer >= 0 injects a sample edge
    // in that layer's first RUN cycle; stop_cache0 returns at cache_clk[0].
    task automatic run_pass(input int r0, input int r1, input int r2, input bit hold0,
                            input int ovr_layer, input bit stop_cache0, output int run2);
        int r[3];
        int rst_at[3];
        int t;
        bit done;
        r[0] = r0; r[1] = r1; r[2] = r2;
        for (int i = 0; i < 3; i++) rst_at[i] = -100;
        sig  = '0;
        run2 = 0;
        t    = 0;
        done = 1'b0;
        conv_out_v = {2'b00, hold0};
        sample_clk = 1'b1;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
            sample_strobes();
            if (t == 1) sample_clk = 1'b0;
            for (int i = 0; i < 3; i++)
                if (conv_rst[i]) rst_at[i] = t;
            if (ovr_layer >= 0) sample_clk = (t == rst_at[ovr_layer] + 1);
            for (int i = 0; i < 3; i++)
                conv_out_v[i] = (hold0 && i == 0) || (r[i] != 0 && t == rst_at[i] + r[i]);
            if (stop_cache0 && cache_clk[0]) done = 1'b1;
            if (t > 1 && !busy) begin
                done = 1'b1;
                run2 = t - rst_at[2] - 1;
            end
        end
        chk("pass_bound", 64'(done), 64'd1);
        conv_out_v = '0;
        sample_clk = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        multi      = 0;
        sig        = '0;
        rst        = 1'b1;
        sample_clk = 1'b1;
        conv_out_v = '0;

        // Reset with sample_clk already high: release must not look like an edge
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sample_strobes();
        end
        chk("rst_strobes", sig, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_overrun", 64'(overrun_cnt), 64'd0);
        chk("rst_last", 64'(last_cycles), 64'd0);
        chk("rst_max", 64'(max_cycles), 64'd0);
        sample_clk = 1'b0;
        @(negedge clk);

        // Normal pass, each layer valid in its 3rd RUN cycle
        run_pass(3, 3, 3, 1'b0, -1, 1'b0, run_last);
        chk("full_sig", sig, SIG_FULL);
        chk("full_last", 64'(last_cycles), 64'd16);
        chk("full_max", 64'(max_cycles), 64'd16);
        chk("full_overrun", 64'(overrun_cnt), 64'd0);
        chk("full_busy", 64'(busy), 64'd0);

        // Stale valid on layer 0: ignored in its first RUN cycle
        run_pass(0, 3, 3, 1'b1, -1, 1'b0, run_last);
        chk("hold0_sig", sig, SIG_FULL);
        chk("hold0_last", 64'(last_cycles), 64'd15);
        chk("hold0_max", 64'(max_cycles), 64'd16);

        // Fastest accepted response, then a slower pass raising max
        run_pass(2, 2, 2, 1'b0, -1, 1'b0, run_last);
        chk("fast_last", 64'(last_cycles), 64'd13);
        run_pass(4, 4, 4, 1'b0, -1, 1'b0, run_last);
        chk("slow_last", 64'(last_cycles), 64'd19);
        chk("slow_max", 64'(max_cycles), 64'd19);

        // Edge during layer 1 RUN is dropped and counted
        run_pass(3, 3, 3, 1'b0, 1, 1'b0, run_last);
        chk("ovr_cnt", 64'(overrun_cnt), 64'd1);
        chk("ovr_sig", sig, SIG_FULL);
        chk("ovr_last", 64'(last_cycles), 64'd16);
        chk("ovr_max", 64'(max_cycles), 64'd19);

        // Layer 2 never responds: 8 RUN cycles then abort
        run_pass(3, 3, 0, 1'b0, -1, 1'b0, run_last);
        chk("to_sig", sig, SIG_TIMEOUT);
        chk("to_run_cycles", 64'(run_last), 64'd8);
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_last", 64'(last_cycles), 64'd16);
        chk("to_overrun", 64'(overrun_cnt), 64'd1);

        // Recovery pass, error stays sticky
        run_pass(3, 3, 3, 1'b0, -1, 1'b0, run_last);
        chk("post_to_sig", sig, SIG_FULL);
        chk("post_to_err", 64'(timeout_err), 64'd1);
        chk("post_to_last", 64'(last_cycles), 64'd16);

        // Reset while caching layer 0
        run_pass(3, 3, 3, 1'b0, -1, 1'b1, run_last);
        chk("mid_sig", sig, SIG_CACHE0);
        rst = 1'b1;
        @(negedge clk);
        sig = '0;
        sample_strobes();
        chk("mid_rst_strobes", sig, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_timeout", 64'(timeout_err), 64'd0);
        chk("mid_rst_overrun", 64'(overrun_cnt), 64'd0);
        chk("mid_rst_last", 64'(last_cycles), 64'd0);
        chk("mid_rst_max", 64'(max_cycles), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_pass(3, 3, 3, 1'b0, -1, 1'b0, run_last);
        chk("restart_sig", sig, SIG_FULL);
        chk("restart_last", 64'(last_cycles), 64'd16);
        chk("restart_max", 64'(max_cycles), 64'd16);

        chk("single_strobe", 64'(multi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
